seq_mux_pipe: RTL and testbench
===============================

// Module: seq_mux_pipe
// PURPOSE
//   Parametrised, registered N-channel selector with valid/ready flow control.
//   Successor to the 2:1 single-bit registered select: generalised in channel count and data width.
//   Adds a 2-entry output buffer and back-pressure.
//   Sits between multiple producer channels and one consumer.
// PARAMETERS
//   CH     2   number of input channels (>=2)
//   W      1   data width per channel (>=1)
//   SELW   1   select width; must satisfy 2**SELW >= CH
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   in_data    in   CH*W    channel i occupies bits [i*W +: W]
//   in_valid   in   CH      per-channel valid
//   in_ready   out  CH      per-channel ready
//   sel        in   SELW    channel select, sampled every cycle
//   out_data   out  W       head-of-buffer data
//   out_valid  out  1       buffer non-empty
//   out_ready  in   1       consumer accepts when out_valid && out_ready
//   sel_err    out  1       registered one-cycle pulse: sel >= CH was presented
//   xfer_cnt   out  16      count of accepted input beats, wraps 0xFFFF->0
// BEHAVIOUR
//   - Clock and reset: one clock domain (clk). rst is synchronous and active-high.
//   - Reset values: buffer empty, out_valid=0, out_data=0, sel_err=0, xfer_cnt=0.
//     in_ready is all-0 during the reset cycle.
//   - Ready: in_ready[i] = (i==sel) && (sel<CH) && !full && !rst.
//     This is combinational from sel and the buffer level; all other bits are 0.
//   - Accept: a beat is accepted when in_valid[sel] && in_ready[sel].
//     The data is written to the buffer tail.
//   - Latency: accept in cycle N -> out_valid=1 with that data in cycle N+1, if the buffer was empty.
//   - Buffer: 2 entries, FIFO order. full = 2 entries; empty = 0 entries.
//   - Simultaneous push and pop:
//     - 1 entry: level stays 1; head advances to the new beat.
//     - 0 entries: push only; no combinational bypass.
//   - Full: in_ready is all 0. A pop in cycle N re-enables ready in cycle N+1.
//     There is no same-cycle full pass-through.
//   - out_data holds its value while out_valid && !out_ready. out_data is stable until popped.
//   - sel changes: may change any cycle. Beats already buffered are unaffected.
//   - Invalid sel (sel >= CH): no accept in that cycle; sel_err=1 in the next cycle.
//   - xfer_cnt increments by 1 per accepted beat, modulo 2**16.
//   - Reset mid-operation: buffered beats are discarded.
//     No out_valid in the cycle after rst, and xfer_cnt=0.
// CONFIGURATION
//   SEQ_MUX_PARITY_EN defined:
//     - Adds output port out_parity (1 bit) = XOR-reduce of the accepted data.
//     - Parity is computed at accept time and stored alongside the data in the buffer.
//     - Reset value 0; stays aligned with out_data.
//   SEQ_MUX_PARITY_EN undefined: no out_parity port and no parity storage; all else identical.
// STRUCTURE
//   Package seq_mux_pkg:
//     - SKID_DEPTH=2
//     - CNT_W=16
//     - function clog2
//     - typedef of the buffer entry {parity, data}
//   Sub-module seq_mux_skid: 2-entry FIFO with push/pop/full/empty, parametrised on entry width.
//   Top level holds: select/ready decode, input mux, sel_err register, xfer_cnt counter.
// TESTING
//   1. Reset: rst=1 for 2 cycles with random inputs
//      -> out_valid=0, out_data=0, sel_err=0, xfer_cnt=0, in_ready=0.
//   2. CH=4, W=8. sel=2, in_valid[2]=1, data 0xA5, out_ready=1
//      -> out_valid with 0xA5 one cycle later; in_ready=4'b0100; xfer_cnt=1.
//   3. Back-pressure: out_ready=0, push 0x11, 0x22, 0x33 on ch1
//      -> in_ready drops after 2 beats. Release out_ready
//      -> outputs 0x11, 0x22, then 0x33; no loss, no duplicate.
//   4. Invalid sel: CH=3, SELW=2, sel=3, all valid
//      -> in_ready=0, sel_err pulses 1 cycle later, xfer_cnt unchanged.
//   5. Reset mid-stream: buffer holding 2 beats, assert rst
//      -> next cycle out_valid=0 and xfer_cnt=0; a new beat passes normally afterwards.
//   6. With SEQ_MUX_PARITY_EN: push 0x07 then 0x03
//      -> out_parity=1, then 0, aligned with out_data.
//      Also: preload xfer_cnt to 0xFFFF, accept one beat -> xfer_cnt wraps to 0.

Source files
------------

// File: rtl/seq_mux_pkg.sv
// ============================================================================
// Module      : seq_mux_pkg
// Description : Shared constants and helpers for the seq_mux_pipe selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mux_pkg;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned CNT_W      = 16;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mux_skid.sv
// ============================================================================
// Module      : seq_mux_skid
// Description : 2-entry FIFO output buffer with push/pop/full/empty,
//               parametrised on entry width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mux_skid
    import seq_mux_pkg::*;
#(
    parameter int unsigned ENTRY_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wr_entry,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rd_entry,
    output logic               full,
    output logic               empty
);

    localparam int unsigned c_PTR_W = clog2(SKID_DEPTH);
    localparam int unsigned c_LVL_W = clog2(SKID_DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [SKID_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_push;
    logic               w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_entry;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign full     = (r_level == c_LVL_W'(SKID_DEPTH));
    assign empty    = (r_level == '0);
    assign rd_entry = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/seq_mux_pipe.sv
// ============================================================================
// Module      : seq_mux_pipe
// Description : Registered N-channel selector with valid/ready flow control,
//               a 2-entry output buffer, select-error flag and beat counter.
//               Optional macro SEQ_MUX_PARITY_EN adds out_parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mux_pipe
    import seq_mux_pkg::*;
#(
    parameter int unsigned CH   = 2,
    parameter int unsigned W    = 1,
    parameter int unsigned SELW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*W-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sel_err,
    output logic [CNT_W-1:0]  xfer_cnt
`ifdef SEQ_MUX_PARITY_EN
    ,
    output logic              out_parity
`endif
);

`ifdef SEQ_MUX_PARITY_EN
    typedef struct packed {
        logic         parity;
        logic [W-1:0] data;
    } entry_t;
`else
    typedef struct packed {
        logic [W-1:0] data;
    } entry_t;
`endif

    logic             w_sel_ok;
    logic             w_mux_valid;
    logic [W-1:0]     w_mux_data;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    entry_t           w_wr_entry;
    entry_t           w_rd_entry;
    logic             r_sel_err;
    logic [CNT_W-1:0] r_xfer_cnt;

    // An out-of-range select matches no channel, so it reads as "not ok".
    always_comb begin
        w_sel_ok    = 1'b0;
        w_mux_valid = 1'b0;
        w_mux_data  = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel == SELW'(i)) begin
                w_sel_ok    = 1'b1;
                w_mux_valid = in_valid[i];
                w_mux_data  = in_data[i*W +: W];
            end
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ready
        assign in_ready[gi] = (sel == SELW'(gi)) && !w_full && !rst;
    end

    assign w_push = w_mux_valid && w_sel_ok && !w_full && !rst;

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.data = w_mux_data;
`ifdef SEQ_MUX_PARITY_EN
        w_wr_entry.parity = ^w_mux_data;
`endif
    end

    seq_mux_skid #(
        .ENTRY_W ($bits(entry_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .wr_entry (w_wr_entry),
        .pop      (out_ready),
        .rd_entry (w_rd_entry),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err  <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_sel_err <= !w_sel_ok;
            if (w_push) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_rd_entry.data;
    assign sel_err   = r_sel_err;
    assign xfer_cnt  = r_xfer_cnt;
`ifdef SEQ_MUX_PARITY_EN
    assign out_parity = w_rd_entry.parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_mux_pipe.sv
// ============================================================================
// Module      : tb_seq_mux_pipe
// Description : Directed self-checking bench for seq_mux_pipe (CH=4 and CH=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mux_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic [1:0]  sel4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic        sel_err4;
    logic [15:0] xfer4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic        sel_err3;
    logic [15:0] xfer3;

`ifdef SEQ_MUX_PARITY_EN
    logic        par4;
    logic        par3;
`endif

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    seq_mux_pipe #(.CH(4), .W(8), .SELW(2)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .sel       (sel4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sel_err   (sel_err4),
        .xfer_cnt  (xfer4)
`ifdef SEQ_MUX_PARITY_EN
        ,
        .out_parity(par4)
`endif
    );

    seq_mux_pipe #(.CH(3), .W(8), .SELW(2)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3),
        .xfer_cnt  (xfer3)
`ifdef SEQ_MUX_PARITY_EN
        ,
        .out_parity(par3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_data4   = '0;
        in_valid4  = '0;
        sel4       = '0;
        out_ready4 = 1'b0;
        in_data3   = '0;
        in_valid3  = '0;
        sel3       = '0;
        out_ready3 = 1'b0;

        // Reset with random inputs
        for (int k = 0; k < 2; k++) begin
            in_data4   = $urandom;
            in_valid4  = 4'($urandom);
            sel4       = 2'($urandom);
            out_ready4 = 1'($urandom);
            in_data3   = 24'($urandom);
            in_valid3  = 3'($urandom);
            sel3       = 2'($urandom);
            out_ready3 = 1'($urandom);
            #1;
            chk("rst_in_ready4", 32'(in_ready4), 32'h0);
            chk("rst_in_ready3", 32'(in_ready3), 32'h0);
            cyc();
            chk("rst_out_valid4", 32'(out_valid4), 32'h0);
            chk("rst_out_data4", 32'(out_data4), 32'h0);
            chk("rst_sel_err4", 32'(sel_err4), 32'h0);
            chk("rst_xfer4", 32'(xfer4), 32'h0);
            chk("rst_sel_err3", 32'(sel_err3), 32'h0);
            chk("rst_xfer3", 32'(xfer3), 32'h0);
        end

        rst        = 1'b0;
        in_valid4  = '0;
        in_valid3  = '0;
        sel4       = 2'd0;
        sel3       = 2'd0;
        out_ready4 = 1'b1;
        out_ready3 = 1'b1;
        in_data4   = '0;
        in_data3   = '0;
        cyc();

        // Single beat on channel 2
        sel4      = 2'd2;
        in_data4  = 32'h00A5_0000;
        in_valid4 = 4'b0100;
        #1;
        chk("s2_in_ready", 32'(in_ready4), 32'h4);
        cyc();
        in_valid4 = '0;
        chk("s2_out_valid", 32'(out_valid4), 32'h1);
        chk("s2_out_data", 32'(out_data4), 32'hA5);
        chk("s2_xfer", 32'(xfer4), 32'h1);
        cyc();
        chk("s2_drained", 32'(out_valid4), 32'h0);

        // Back-pressure on channel 1
        out_ready4 = 1'b0;
        sel4       = 2'd1;
        in_valid4  = 4'b0010;
        in_data4   = 32'h0000_1100;
        #1;
        chk("s3_ready_a", 32'(in_ready4), 32'h2);
        cyc();
        in_data4 = 32'h0000_2200;
        #1;
        chk("s3_ready_b", 32'(in_ready4), 32'h2);
        cyc();
        in_data4 = 32'h0000_3300;
        #1;
        chk("s3_ready_full", 32'(in_ready4), 32'h0);
        cyc();
        chk("s3_head_a", 32'(out_data4), 32'h11);
        chk("s3_xfer_a", 32'(xfer4), 32'h3);
        cyc();
        chk("s3_hold", 32'(out_data4), 32'h11);
        out_ready4 = 1'b1;
        cyc();
        chk("s3_head_b", 32'(out_data4), 32'h22);
        chk("s3_ready_reen", 32'(in_ready4), 32'h2);
        cyc();
        in_valid4 = '0;
        chk("s3_head_c", 32'(out_data4), 32'h33);
        chk("s3_valid_c", 32'(out_valid4), 32'h1);
        chk("s3_xfer_c", 32'(xfer4), 32'h4);
        cyc();
        chk("s3_empty", 32'(out_valid4), 32'h0);

        // Invalid select on the 3-channel instance
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        in_data3  = 24'h123456;
        #1;
        chk("s4_in_ready", 32'(in_ready3), 32'h0);
        cyc();
        chk("s4_sel_err", 32'(sel_err3), 32'h1);
        chk("s4_xfer", 32'(xfer3), 32'h0);
        chk("s4_no_valid", 32'(out_valid3), 32'h0);
        sel3      = 2'd0;
        in_valid3 = '0;
        cyc();
        chk("s4_sel_err_clr", 32'(sel_err3), 32'h0);

        // Reset with two beats buffered
        out_ready4 = 1'b0;
        sel4       = 2'd1;
        in_valid4  = 4'b0010;
        in_data4   = 32'h0000_4400;
        cyc();
        in_data4 = 32'h0000_5500;
        cyc();
        chk("s5_pre_valid", 32'(out_valid4), 32'h1);
        chk("s5_pre_xfer", 32'(xfer4), 32'h6);
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        in_valid4 = '0;
        chk("s5_valid", 32'(out_valid4), 32'h0);
        chk("s5_xfer", 32'(xfer4), 32'h0);
        chk("s5_data", 32'(out_data4), 32'h0);
        out_ready4 = 1'b1;
        in_data4   = 32'h0000_6600;
        in_valid4  = 4'b0010;
        cyc();
        in_valid4 = '0;
        chk("s5_new_valid", 32'(out_valid4), 32'h1);
        chk("s5_new_data", 32'(out_data4), 32'h66);
        chk("s5_new_xfer", 32'(xfer4), 32'h1);
        cyc();

`ifdef SEQ_MUX_PARITY_EN
        // Parity follows data through the buffer
        out_ready4 = 1'b0;
        sel4       = 2'd0;
        in_valid4  = 4'b0001;
        in_data4   = 32'h0000_0007;
        cyc();
        chk("p_data_a", 32'(out_data4), 32'h07);
        chk("p_par_a", 32'(par4), 32'h1);
        in_data4 = 32'h0000_0003;
        cyc();
        in_valid4  = '0;
        out_ready4 = 1'b1;
        cyc();
        chk("p_data_b", 32'(out_data4), 32'h03);
        chk("p_par_b", 32'(par4), 32'h0);
        cyc();
`endif

        // Counter wrap: one accept per cycle from zero
        rst = 1'b1;
        cyc();
        rst        = 1'b0;
        sel4       = 2'd3;
        in_data4   = 32'h5A00_0000;
        in_valid4  = 4'b1000;
        out_ready4 = 1'b1;
        repeat (65535) cyc();
        chk("w_xfer_max", 32'(xfer4), 32'hFFFF);
        cyc();
        chk("w_xfer_wrap", 32'(xfer4), 32'h0);
        chk("w_out_data", 32'(out_data4), 32'h5A);
        in_valid4 = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

`default_nettype wire
